// File: rtl/reg_file_rd_mux.sv
// reg_file_rd_mux: parametrised register file with one write port and NUM_RD
// independent registered read ports, write-to-read bypass and per-port
// read-valid flags.
//
// Optional feature macro: REG_ZERO_HARDWIRE_EN
//   defined   -> entry 0 is architectural zero (writes dropped, reads return 0,
//                including the bypass case)
//   undefined -> entry 0 is an ordinary register
//
// Handshake: there is no ready; the block accepts a request on every edge.
// rd_en[p]=1 at edge k is a request whose answer (rd_data[p], rd_valid[p]=1)
// is visible after edge k. rd_en[p]=0 at edge k clears rd_valid[p] and leaves
// rd_data[p] holding its previous value.
module reg_file_rd_mux #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  // One extra bit so DEPTH itself (up to 256) is representable for range checks.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_addr_ok;
  logic wr_ok;

  // Decide whether this edge's write really lands in storage.
  always_comb begin
    wr_addr_ok = ({1'b0, wr_addr} < DEPTH_W);
    wr_ok      = wr_en && wr_addr_ok;
`ifdef REG_ZERO_HARDWIRE_EN
    if (wr_addr == '0) begin
      wr_ok = 1'b0;
    end
`endif
  end

  // Storage: cleared on reset, written on a qualified write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_ok;
    logic              ra_zero;
    logic              bypass;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Select the operand for this port: out-of-range -> 0, bypass -> write data.
    always_comb begin
      ra      = rd_addr[p*ADDR_W +: ADDR_W];
      ra_ok   = ({1'b0, ra} < DEPTH_W);
      ra_zero = 1'b0;
`ifdef REG_ZERO_HARDWIRE_EN
      ra_zero = (ra == '0);
`endif
      bypass  = wr_ok && (wr_addr == ra);
      if (!ra_ok || ra_zero) begin
        sel_data = '0;
      end else if (bypass) begin
        sel_data = wr_data;
      end else begin
        sel_data = mem[ra];
      end
    end

    // Registered read port: data updates only on a request, valid every edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[p];
        if (rd_en[p]) begin
          data_q <= sel_data;
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_valid[p]                 = valid_q;
  end

endmodule

// File: tb/tb_reg_file_rd_mux.sv
// tb_reg_file_rd_mux: directed-vector bench for reg_file_rd_mux, covering a
// DEPTH=16 / NUM_RD=2 instance and a DEPTH=12 instance for the out-of-range
// address cases. Expectations for address 0 follow REG_ZERO_HARDWIRE_EN.
module tb_reg_file_rd_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DEPTH=16 instance ----------------
  logic         wr_en   = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [63:0]  wr_data = '0;
  logic [1:0]   rd_en   = '0;
  logic [7:0]   rd_addr = '0;
  logic [127:0] rd_data;
  logic [1:0]   rd_valid;

  reg_file_rd_mux #(.DATA_W(64), .DEPTH(16), .NUM_RD(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // ---------------- DEPTH=12 instance ----------------
  logic         w12_en   = 1'b0;
  logic [3:0]   w12_addr = '0;
  logic [63:0]  w12_data = '0;
  logic [1:0]   r12_en   = '0;
  logic [7:0]   r12_addr = '0;
  logic [127:0] r12_data;
  logic [1:0]   r12_valid;

  reg_file_rd_mux #(.DATA_W(64), .DEPTH(12), .NUM_RD(2)) dut12 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w12_en),
    .wr_addr  (w12_addr),
    .wr_data  (w12_data),
    .rd_en    (r12_en),
    .rd_addr  (r12_addr),
    .rd_data  (r12_data),
    .rd_valid (r12_valid)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and land 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = '0;
  endtask

  task automatic write(input logic [3:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; rd_en = '0;
    cycle();
    wr_en = 1'b0;
  endtask

  logic [63:0] zero_exp;
  logic [63:0] v;

  initial begin
    // reset state while rst is held
    #2;
    check("reset_valid", {62'd0, rd_valid}, 64'd0);
    check("reset_data0", rd_data[63:0], 64'd0);
    check("reset_data1", rd_data[127:64], 64'd0);
    cycle();
    cycle();
    rst = 1'b0;

    // basic write / read / hold
    write(4'd3, 64'h1234);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
    cycle();
    check("basic_data", rd_data[63:0], 64'h1234);
    check("basic_valid", {62'd0, rd_valid}, 64'h1);
    rd_en = 2'b00;
    cycle();
    check("hold_valid", {62'd0, rd_valid}, 64'h0);
    check("hold_data", rd_data[63:0], 64'h1234);

    // bypass on both ports
    write(4'd7, 64'hAAAA);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 64'h5555;
    rd_en = 2'b11; rd_addr = {4'd7, 4'd7};
    cycle();
    wr_en = 1'b0;
    check("bypass_p0", rd_data[63:0], 64'h5555);
    check("bypass_p1", rd_data[127:64], 64'h5555);
    check("bypass_valid", {62'd0, rd_valid}, 64'h3);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
    cycle();
    check("after_bypass", rd_data[63:0], 64'h5555);
    idle();

    // full sweep: entry i = i*0x0101, ports read opposite ends each cycle
    for (int i = 0; i < 16; i++) write(4'(i), 64'(i) * 64'h0101);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'(i) * 64'h0101);
    for (int i = 0; i < 16; i++) begin
      rd_en = 2'b11; rd_addr = {4'(15 - i), 4'(i)};
      cycle();
      check($sformatf("sweep_p0_%0d", i), rd_data[63:0], exp_q[i]);
      check($sformatf("sweep_p1_%0d", i), rd_data[127:64], exp_q[15 - i]);
      check($sformatf("sweep_valid_%0d", i), {62'd0, rd_valid}, 64'h3);
    end
    idle();

    // address 0 written and read at the same edge, then read again
`ifdef REG_ZERO_HARDWIRE_EN
    zero_exp = 64'h0;
`else
    zero_exp = 64'hFFFF;
`endif
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 64'hFFFF;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd0};
    cycle();
    wr_en = 1'b0;
    check("zero_bypass", rd_data[63:0], zero_exp);
    check("zero_bypass_valid", {62'd0, rd_valid}, 64'h1);
    cycle();
    check("zero_reread", rd_data[63:0], zero_exp);
    idle();

    // asynchronous reset mid-operation
    write(4'd5, 64'hDEAD_BEEF);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
    cycle();
    check("pre_reset_data", rd_data[63:0], 64'hDEAD_BEEF);
    check("pre_reset_valid", {62'd0, rd_valid}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {62'd0, rd_valid}, 64'h0);
    check("async_rst_data", rd_data[63:0], 64'h0);
    rst = 1'b0;
    cycle();
    check("post_reset_data", rd_data[63:0], 64'h0);
    check("post_reset_valid", {62'd0, rd_valid}, 64'h1);
    idle();

    // DEPTH=12: out-of-range write dropped, out-of-range read gives 0 valid
    w12_en = 1'b1; w12_addr = 4'd11; w12_data = 64'h11;
    cycle();
    w12_addr = 4'd13; w12_data = 64'hFF;
    cycle();
    w12_en = 1'b0;
    r12_en = 2'b11; r12_addr = {4'd12, 4'd13};
    cycle();
    check("oor13_data", r12_data[63:0], 64'h0);
    check("oor12_data", r12_data[127:64], 64'h0);
    check("oor_valid", {62'd0, r12_valid}, 64'h3);
    for (int i = 0; i < 12; i++) begin
      r12_en = 2'b01; r12_addr = {4'd0, 4'(i)};
      cycle();
      v = (i == 11) ? 64'h11 : 64'h0;
      check($sformatf("d12_entry_%0d", i), r12_data[63:0], v);
    end
    r12_en = 2'b00;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
